// File: rtl/ro_freq_meter_if.sv
// Control/result bundle of the ring-oscillator frequency meter.
// The master drives window requests; the slave (the meter) returns the counts.
`timescale 1ns/1ps
interface ro_freq_meter_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             continuous;
    logic             abort;
    logic             busy;
    logic [CNT_W-1:0] result;
    logic             result_valid;
    logic             ro_dead;

    modport master (
        output start, continuous, abort,
        input  busy, result, result_valid, ro_dead
    );

    modport slave (
        input  start, continuous, abort,
        output busy, result, result_valid, ro_dead
    );
endinterface

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: edges are counted in the RO domain, only a
// Gray-coded count crosses into clk, and windows difference two synchronized snapshots.
`timescale 1ns/1ps
module ro_freq_meter #(
    parameter int CNT_W       = 32,
    parameter int GATE_CYCLES = 100000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ro_clk,
    ro_freq_meter_if.slave      bus
);
    localparam int             GC_W      = $clog2(GATE_CYCLES);
    localparam logic [GC_W-1:0] GATE_LOAD = GC_W'(GATE_CYCLES - 1);

    typedef enum logic {IDLE, GATE} state_t;

    function automatic logic [CNT_W-1:0] bin2gray(input logic [CNT_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [CNT_W-1:0] gray2bin(input logic [CNT_W-1:0] g);
        logic [CNT_W-1:0] b;
        b = g;
        for (int i = CNT_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // RO domain: free-running counter, Gray copy registered alongside it
    logic [CNT_W-1:0] ro_bin_q, ro_bin_d;
    logic [CNT_W-1:0] ro_gray_q;

    assign ro_bin_d = ro_bin_q + CNT_W'(1);

    always_ff @(posedge ro_clk or posedge reset) begin
        if (reset) begin
            ro_bin_q  <= '0;
            ro_gray_q <= '0;
        end else begin
            ro_bin_q  <= ro_bin_d;
            ro_gray_q <= bin2gray(ro_bin_d);
        end
    end

    // clk domain: Gray synchronizer, then binary snapshot
    logic [CNT_W-1:0] sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] snap_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            snap_q <= '0;
        end else begin
            sync_q[0] <= ro_gray_q;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            snap_q <= gray2bin(sync_q[SYNC_STAGES-1]);
        end
    end

    // Window control; base and end both come from snap_q so sync latency cancels
    state_t           state_q;
    logic [CNT_W-1:0] base_q;
    logic [GC_W-1:0]  gate_cnt_q;
    logic [CNT_W-1:0] result_q, result_d;
    logic             vld_q;
    logic             dead_q;
    logic             busy_q;

    assign result_d = snap_q - base_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            gate_cnt_q <= '0;
            result_q   <= '0;
            vld_q      <= 1'b0;
            dead_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        base_q     <= snap_q;
                        gate_cnt_q <= GATE_LOAD;
                        state_q    <= GATE;
                        busy_q     <= 1'b1;
                    end
                end
                GATE: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (gate_cnt_q != '0) begin
                        gate_cnt_q <= gate_cnt_q - GC_W'(1);
                    end else begin
                        result_q <= result_d;
                        dead_q   <= (result_d == '0);
                        vld_q    <= 1'b1;
                        // Back-to-back windows share the boundary snapshot: no lost edges
                        if (bus.continuous) begin
                            base_q     <= snap_q;
                            gate_cnt_q <= GATE_LOAD;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
    assign bus.result_valid = vld_q;
    assign bus.ro_dead      = dead_q;
endmodule
